// File: rtl/gray_pkg.sv
// gray_pkg: step direction codes and monitor FSM states shared by Gray code consumers
package gray_pkg;
  localparam logic [1:0] DIR_HOLD    = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b01;
  localparam logic [1:0] DIR_DOWN    = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decode; gray in, bin out, both WIDTH bits
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_step_monitor.sv
// gray_step_monitor: classifies sampled Gray steps (clk, reset active-low sync, in_valid, gray_in -> bin_out, dir, wrap_pulse, step_err, locked, lap_count, err_count)
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic [1:0]       dir,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic             locked,
  output logic [CNT_W-1:0] lap_count,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] delta;
  gray2bin #(.WIDTH(WIDTH)) u_dec (.gray(gray_in), .bin(bin_new));
  assign delta = bin_new - bin_out;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bin_out    <= '0;
      dir        <= DIR_HOLD;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      locked     <= 1'b0;
      lap_count  <= '0;
      err_count  <= '0;
    end else begin
      dir        <= DIR_HOLD;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      if (in_valid) begin
        bin_out <= bin_new;
        if (state != TRACK) begin
          state  <= TRACK;
          locked <= 1'b1;
        end else if (delta == WIDTH'(1)) begin
          dir <= DIR_UP;
          if (bin_out == MAX) begin
            wrap_pulse <= 1'b1;
            lap_count  <= lap_count + CNT_W'(1);
          end
        end else if (delta == MAX) begin
          dir <= DIR_DOWN;
          if (bin_out == '0) begin
            wrap_pulse <= 1'b1;
            lap_count  <= lap_count - CNT_W'(1);
          end
        end else if (delta != '0) begin
          dir       <= DIR_ILLEGAL;
          step_err  <= 1'b1;
          err_count <= &err_count ? err_count : err_count + CNT_W'(1);
          state     <= RESYNC;
          locked    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gray_step_monitor.sv
// tb_gray_step_monitor: directed and randomized checks of gray_step_monitor against a behavioural model
module tb_gray_step_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] gray_in = '0;
  logic [2:0] bin_out, bin_out2;
  logic [1:0] dir, dir2;
  logic       wrap_pulse, wrap_pulse2, step_err, step_err2, locked, locked2;
  logic [7:0] lap_count, err_count;
  logic [1:0] lap_count2, err_count2;
  int total = 0;
  int bad = 0;
  bit chk_on = 0;
  gray_step_monitor #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .gray_in(gray_in),
    .bin_out(bin_out), .dir(dir), .wrap_pulse(wrap_pulse), .step_err(step_err),
    .locked(locked), .lap_count(lap_count), .err_count(err_count)
  );
  gray_step_monitor #(.WIDTH(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .gray_in(gray_in),
    .bin_out(bin_out2), .dir(dir2), .wrap_pulse(wrap_pulse2), .step_err(step_err2),
    .locked(locked2), .lap_count(lap_count2), .err_count(err_count2)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] gray(input int n);
    logic [2:0] v;
    v = 3'(n);
    return v ^ (v >> 1);
  endfunction
  function automatic int decode(input logic [2:0] g);
    for (int n = 0; n < 8; n++) if (gray(n) == g) return n;
    return 0;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  bit have_ref = 0;
  int m_bin = 0, m_dir = 0, m_wrap = 0, m_err = 0, lap = 0, err8 = 0, err2 = 0;
  always @(posedge clk) begin
    int n, d;
    m_dir = 0;
    m_wrap = 0;
    m_err = 0;
    if (!reset) begin
      have_ref = 0; m_bin = 0; lap = 0; err8 = 0; err2 = 0;
    end else if (in_valid) begin
      n = decode(gray_in);
      if (!have_ref) have_ref = 1;
      else begin
        d = (n - m_bin + 8) % 8;
        if (d == 1) begin
          m_dir = 1;
          if (n == 0) begin m_wrap = 1; lap++; end
        end else if (d == 7) begin
          m_dir = 2;
          if (n == 7) begin m_wrap = 1; lap--; end
        end else if (d != 0) begin
          m_dir = 3; m_err = 1; have_ref = 0;
          err8 = err8 < 255 ? err8 + 1 : 255;
          err2 = err2 < 3 ? err2 + 1 : 3;
        end
      end
      m_bin = n;
    end
  end
  always @(negedge clk) if (chk_on) begin
    logic [7:0] l8;
    logic [1:0] l2;
    l8 = 8'(lap);
    l2 = 2'(lap);
    chk("bin_out", int'(bin_out), m_bin);
    chk("dir", int'(dir), m_dir);
    chk("wrap_pulse", int'(wrap_pulse), m_wrap);
    chk("step_err", int'(step_err), m_err);
    chk("locked", int'(locked), int'(have_ref));
    chk("lap_count", int'(lap_count), int'(l8));
    chk("err_count", int'(err_count), err8);
    chk("bin_out2", int'(bin_out2), m_bin);
    chk("dir2", int'(dir2), m_dir);
    chk("lap_count2", int'(lap_count2), int'(l2));
    chk("err_count2", int'(err_count2), err2);
  end
  task automatic cyc(input logic r, input logic v, input logic [2:0] g);
    reset = r;
    in_valid = v;
    gray_in = g;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cur;
    cyc(0, 0, 3'b000);
    chk_on = 1;
    cyc(0, 1, 3'b011);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lap", int'(lap_count), 0);
    chk("rst_err", int'(err_count), 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, gray(i));
      chk("up_bin", int'(bin_out), i % 8);
      chk("up_dir", int'(dir), i == 0 ? 0 : 1);
      chk("up_wrap", int'(wrap_pulse), i == 8 ? 1 : 0);
      chk("up_locked", int'(locked), 1);
    end
    chk("up_lap", int'(lap_count), 1);
    cyc(0, 0, 3'b000);
    cyc(1, 1, 3'b000);
    for (int i = 1; i < 9; i++) begin
      cyc(1, 1, gray(8 - i));
      chk("dn_bin", int'(bin_out), (8 - i) % 8);
      chk("dn_dir", int'(dir), 2);
      chk("dn_wrap", int'(wrap_pulse), i == 1 ? 1 : 0);
    end
    chk("dn_lap", int'(lap_count), 255);
    chk("dn_lap2", int'(lap_count2), 3);
    cyc(1, 1, 3'b001);
    cyc(1, 1, 3'b101);
    chk("ill_dir", int'(dir), 3);
    chk("ill_err", int'(step_err), 1);
    chk("ill_cnt", int'(err_count), 1);
    chk("ill_locked", int'(locked), 0);
    chk("ill_bin", int'(bin_out), 6);
    cyc(1, 1, 3'b111);
    chk("prime_dir", int'(dir), 0);
    chk("prime_locked", int'(locked), 1);
    chk("prime_bin", int'(bin_out), 5);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 3'(i + 2));
      chk("idle_bin", int'(bin_out), 5);
      chk("idle_dir", int'(dir), 0);
    end
    cyc(1, 1, 3'b111);
    chk("same_dir", int'(dir), 0);
    chk("same_wrap", int'(wrap_pulse), 0);
    cyc(0, 0, 3'b000);
    for (int i = 0; i < 17; i++) cyc(1, 1, gray(i));
    cyc(1, 1, gray(4));
    chk("pre_lap", int'(lap_count), 2);
    chk("pre_err", int'(err_count), 1);
    cyc(0, 1, gray(5));
    chk("mid_bin", int'(bin_out), 0);
    chk("mid_lap", int'(lap_count), 0);
    chk("mid_err", int'(err_count), 0);
    chk("mid_locked", int'(locked), 0);
    cyc(1, 1, gray(1));
    chk("rel_dir", int'(dir), 0);
    chk("rel_locked", int'(locked), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, gray(5));
      chk("sat_pulse", int'(step_err2), 1);
      chk("sat_cnt2", int'(err_count2), i < 3 ? i + 1 : 3);
      cyc(1, 1, gray(1));
    end
    cur = 1;
    for (int i = 0; i < 3000; i++) begin
      int k, d;
      k = int'($urandom_range(0, 9));
      d = k < 4 ? 1 : k < 7 ? 7 : k < 8 ? 0 : int'($urandom_range(2, 6));
      cur = (cur + d) % 8;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, gray(cur));
    end
    cyc(1, 0, 3'b000);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
